// File: rtl/emboss_filter_if.sv
// ============================================================================
// Module   : emboss_filter_if
// Purpose  : Pixel stream bundle between a pixel source and the emboss filter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface emboss_filter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pixel_valid;
  logic [DATA_WIDTH-1:0] pixel_in;
  logic                  pixel_out_valid;
  logic [DATA_WIDTH-1:0] pixel_out;

  modport master (
    output pixel_valid,
    output pixel_in,
    input  pixel_out_valid,
    input  pixel_out
  );

  modport slave (
    input  pixel_valid,
    input  pixel_in,
    output pixel_out_valid,
    output pixel_out
  );
endinterface

`default_nettype wire

// File: rtl/emboss_filter.sv
// ============================================================================
// Module   : emboss_filter
// Purpose  : Streaming 3x3 emboss filter, two line buffers, latency 2 edges.
//            Define EMBOSS_BIAS_EN for a mid-gray bias of 128 (else bias 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module emboss_filter #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 464,
  parameter int DATA_WIDTH   = 8
) (
  input  logic           clk,
  input  logic           rst,
  emboss_filter_if.slave bus
);

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int SW = DATA_WIDTH + 3;
  localparam int OW = DATA_WIDTH + 4;

`ifdef EMBOSS_BIAS_EN
  localparam logic signed [OW-1:0] C_BIAS = OW'(128);
`else
  localparam logic signed [OW-1:0] C_BIAS = OW'(0);
`endif
  localparam logic signed [OW-1:0] C_MAX = OW'((1 << DATA_WIDTH) - 1);

  function automatic logic signed [SW-1:0] ext(input logic [DATA_WIDTH-1:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic [DATA_WIDTH-1:0] clamp(input logic signed [OW-1:0] v);
    if (v < 0)          return '0;
    else if (v > C_MAX) return '1;
    else                return v[DATA_WIDTH-1:0];
  endfunction

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2
  logic [DATA_WIDTH-1:0] lb1_q [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_q [IMAGE_WIDTH];

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  // Window: index 0 = column c-2, 2 = column c; bottom c-2 has zero weight
  logic [DATA_WIDTH-1:0] top_q [3];
  logic [DATA_WIDTH-1:0] mid_q [3];
  logic [DATA_WIDTH-1:0] bot1_q, bot2_q;

  logic                  v1_q, v2_q, valid_q;
  logic                  border1_q, border2_q;
  logic signed [SW-1:0]  sum_q, sum_d;
  logic signed [OW-1:0]  biased;
  logic [DATA_WIDTH-1:0] pix_q;
  logic [DATA_WIDTH-1:0] lb1_rd, lb2_rd;
  logic                  accept;

  assign accept = bus.pixel_valid;
  assign lb1_rd = lb1_q[col_q];
  assign lb2_rd = lb2_q[col_q];

  assign sum_d = ext(mid_q[2]) + ext(bot1_q) + ext(bot2_q)
               - ext(top_q[0]) - ext(top_q[1]) - ext(mid_q[0]);
  assign biased = {sum_q[SW-1], sum_q} + C_BIAS;

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= bus.pixel_in;
      lb2_q[col_q] <= lb1_rd;
      top_q[0]     <= top_q[1];
      top_q[1]     <= top_q[2];
      top_q[2]     <= lb2_rd;
      mid_q[0]     <= mid_q[1];
      mid_q[1]     <= mid_q[2];
      mid_q[2]     <= lb1_rd;
      bot1_q       <= bot2_q;
      bot2_q       <= bus.pixel_in;
      border1_q    <= (row_q < RW'(2)) || (col_q < CW'(2));
    end
    if (v1_q) begin
      sum_q     <= sum_d;
      border2_q <= border1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      valid_q <= 1'b0;
      pix_q   <= '0;
    end else begin
      if (accept) begin
        if (col_q == CW'(IMAGE_WIDTH - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RW'(IMAGE_HEIGHT - 1)) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      v1_q    <= accept;
      v2_q    <= v1_q;
      valid_q <= v2_q;
      // Border pixels ignore the window, whose contents are stale there
      if (v2_q) pix_q <= border2_q ? clamp(C_BIAS) : clamp(biased);
    end
  end

  assign bus.pixel_out_valid = valid_q;
  assign bus.pixel_out       = pix_q;

endmodule

`default_nettype wire

// File: tb/tb_emboss_filter.sv
// ============================================================================
// Module   : tb_emboss_filter
// Purpose  : Self-checking bench for emboss_filter on a reduced 16x6 raster.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_emboss_filter;

  localparam int W  = 16;
  localparam int H  = 6;
  localparam int DW = 8;
`ifdef EMBOSS_BIAS_EN
  localparam int B = 128;
`else
  localparam int B = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  emboss_filter_if #(.DATA_WIDTH(DW)) bus();

  emboss_filter #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int f;
    int r;
    int c;
    int v;
  } exp_t;

  exp_t q[$];
  int   img [H][W];
  int   rnd [H][W];
  int   act [2][H][W];
  int   mr, mc, mf;
  bit [2:0] hist;
  int   last_exp;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  bit   started = 1'b0;

  function automatic int clampi(int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int model_out(int r, int c);
    int s;
    if (r < 2 || c < 2) return clampi(B);
    s = -img[r-2][c-2] - img[r-2][c-1] - img[r-1][c-2]
        + img[r-1][c] + img[r][c-1] + img[r][c];
    return clampi(s + B);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Model: record accepted pixels in raster position, queue the expected output
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        hist = '0;
        mr = 0; mc = 0; mf = 0;
        q.delete();
        last_exp = 0;
      end else begin
        hist = {hist[1:0], bus.pixel_valid};
        if (bus.pixel_valid) begin
          img[mr][mc] = int'(bus.pixel_in);
          q.push_back('{mf & 1, mr, mc, model_out(mr, mc)});
          mc++;
          if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) begin
              mr = 0;
              mf++;
            end
          end
        end
      end
    end
  end

  // Compare on the falling edge, away from the active edge
  initial begin
    exp_t e;
    wait (started);
    forever begin
      @(negedge clk);
      check("valid", int'(bus.pixel_out_valid), int'(hist[2]));
      if (bus.pixel_out_valid) pulses++;
      if (hist[2]) begin
        if (q.size() == 0) begin
          check("queue_nonempty", 0, 1);
        end else begin
          e = q.pop_front();
          last_exp = e.v;
          if (bus.pixel_out_valid) begin
            act[e.f][e.r][e.c] = int'(bus.pixel_out);
            check($sformatf("pixel(%0d,%0d)", e.r, e.c), int'(bus.pixel_out), e.v);
          end
        end
      end else if (!bus.pixel_out_valid) begin
        check("hold", int'(bus.pixel_out), last_exp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.pixel_valid = 1'b0;
    end
  endtask

  task automatic send(input int v);
    @(posedge clk); #1;
    bus.pixel_valid = 1'b1;
    bus.pixel_in    = 8'(v);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.pixel_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic frame(input int kind, input int gap);
    int v;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (kind)
          0:       v = 100;
          1:       v = (c < W/2) ? 0 : 255;
          2:       v = (c < W/2) ? 255 : 0;
          default: v = rnd[r][c];
        endcase
        send(v);
        if (gap > 0) idle(gap);
      end
    end
  endtask

  task automatic drain(input string name);
    idle(5);
    check({name, "_drained"}, q.size(), 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        rnd[r][c] = int'($urandom_range(0, 255));
    @(posedge clk);
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, no pulses while idle
    idle(3);
    check("reset_pulses", pulses, 0);
    check("reset_out", int'(bus.pixel_out), 0);

    // Single pixel: one pulse, border value
    pulses = 0;
    send(200);
    drain("single");
    check("single_pulses", pulses, 1);
    check("single_value", act[0][0][0], B);

    // Constant frame, one pixel every two cycles
    do_reset();
    pulses = 0;
    frame(0, 1);
    drain("const");
    check("const_pulses", pulses, W*H);
    bad = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (act[0][r][c] != B) bad++;
    check("const_all_bias", bad, 0);

    // Rising vertical edge at column W/2
    do_reset();
    frame(1, 0);
    drain("edge");
    check("edge_c8",  act[0][3][8],  255);
    check("edge_c9",  act[0][3][9],  255);
    check("edge_c10", act[0][3][10], B);
    check("edge_c7",  act[0][3][7],  B);
    check("edge_row1", act[0][1][8], B);

    // Falling vertical edge
    do_reset();
    frame(2, 0);
    drain("inv");
    check("inv_c8",  act[0][4][8],  0);
    check("inv_c9",  act[0][4][9],  0);
    check("inv_c10", act[0][4][10], B);
    check("inv_c7",  act[0][4][7],  B);

    // Reset mid-row, then two random frames back to back
    do_reset();
    for (int i = 0; i < 20; i++) send(rnd[0][i % W] ^ 8'h5a);
    do_reset();
    frame(3, 0);
    frame(3, 0);
    drain("rand");
    bad = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (act[0][r][c] != act[1][r][c]) bad++;
    check("frames_equal", bad, 0);
    bad = 0;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          if ((r < 2 || c < 2) && act[f][r][c] != B) bad++;
    check("rand_border", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
